// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Handshaked datapath ALU. Add/sub/and/not and three shifts
//             complete in one cycle; multiply runs as WIDTH shift-add steps.
//             Result and 3-bit status flags are registered.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       Z
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;   // count must reach WIDTH itself
  localparam int MSB = WIDTH - 1;

  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]     mplier_q, mplier_d; // multiplier, shifted right each step
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [2:0]           z_q, z_d;
  logic                 vld_q, vld_d;

  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_ovf;
  logic [2*WIDTH-1:0]   acc_step;

  assign shamt    = Bin[SHW-1:0];
  assign in_ready = (state_q == S_IDLE);
  assign out_valid = vld_q;
  assign out       = out_q;
  assign Z         = z_q;

  // Single-cycle result and overflow for the non-multiply opcodes
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (ALUop)
      OP_ADD: begin
        sc_res = Ain + Bin;
        sc_ovf = (Ain[MSB] == Bin[MSB]) && (sc_res[MSB] != Ain[MSB]);
      end
      OP_SUB: begin
        sc_res = Ain - Bin;
        sc_ovf = (Ain[MSB] != Bin[MSB]) && (sc_res[MSB] == Bin[MSB]);
      end
      OP_AND: sc_res = Ain & Bin;
      OP_NOT: sc_res = ~Bin;
      OP_SHL: sc_res = Ain << shamt;
      OP_SHR: sc_res = Ain >> shamt;
      OP_ASR: sc_res = $unsigned($signed(Ain) >>> shamt);
      default: sc_res = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
  always_comb begin
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // Next-state logic: accept, single-cycle writeback, iterative multiply
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    out_d    = out_q;
    z_d      = z_q;
    vld_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (ALUop == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, Ain};
            mplier_d = Bin;
            acc_d    = '0;
            count_d  = CNT_INIT;
            state_d  = S_MUL;
          end else begin
            out_d = sc_res;
            z_d   = {sc_ovf, sc_res[MSB], (sc_res == '0)};
            vld_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          out_d   = acc_step[WIDTH-1:0];
          z_d     = {(|acc_step[2*WIDTH-1:WIDTH]), acc_step[MSB],
                     (acc_step[WIDTH-1:0] == '0)};
          vld_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset also aborts any multiply in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      z_q      <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      z_q      <= z_d;
      vld_q    <= vld_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq (WIDTH=16) with an arithmetic
//             reference model and randomized operations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  Ain, Bin;
  logic [2:0]    ALUop;
  logic          out_valid;
  logic [W-1:0]  out;
  logic [2:0]    Z;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop),
    .out_valid(out_valid), .out(out), .Z(Z)
  );

  always #5 clk = ~clk;

  // Reference: returns {Z, out} computed with plain integer arithmetic
  function automatic logic [18:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    int          sa, sb, s, amt;
    longint      p;
    logic [15:0] o;
    logic        v;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    amt = int'(b[3:0]);
    v   = 1'b0;
    o   = '0;
    case (op)
      3'd0: begin s = sa + sb; o = 16'(s); v = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; o = 16'(s); v = (s > 32767) || (s < -32768); end
      3'd2: o = a & b;
      3'd3: o = ~b;
      3'd4: begin p = longint'(a) * (longint'(1) << amt); o = 16'(p); end
      3'd5: o = 16'(int'(a) / (1 << amt));
      3'd6: begin s = sa >>> amt; o = 16'(s); end
      default: begin
        p = longint'(a) * longint'(b);
        o = 16'(p);
        v = (p >= 65536);
      end
    endcase
    return {v, o[15], (o == 16'h0), o};
  endfunction

  // Issue one operation, wait for its result, check latency, out and Z
  task automatic do_op(input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input string name);
    logic [18:0] exp;
    int          cyc, exp_cyc;
    exp     = model(op, a, b);
    exp_cyc = (op == 3'b111) ? W : 0;
    @(negedge clk);
    Ain = a; Bin = b; ALUop = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      // noise that a busy block must ignore
      Ain = 16'($urandom); Bin = 16'($urandom); ALUop = 3'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (cyc !== exp_cyc || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles valid=%b, want %0d", name, cyc, out_valid, exp_cyc);
    end
    n_cmp++;
    if ({Z, out} !== exp) begin
      n_fail++;
      $display("FAIL %s result: got out=%h Z=%b, want out=%h Z=%b", name, out, Z,
               exp[15:0], exp[18:16]);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready: got in_ready=%b, want 1", name, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; Ain = '0; Bin = '0; ALUop = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, in_ready, Z, out} !== {1'b0, 1'b1, 3'b000, 16'h0}) begin
      n_fail++;
      $display("FAIL reset: got valid=%b ready=%b Z=%b out=%h, want 0 1 000 0000",
               out_valid, in_ready, Z, out);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_addsub();
    do_op(3'b000, 16'h7FFF, 16'h0001, "add_ovf");
    do_op(3'b001, 16'h0005, 16'h0005, "sub_zero");
    do_op(3'b001, 16'h8000, 16'h0001, "sub_ovf");
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [3] = '{3'b010, 3'b011, 3'b100};
    logic [15:0] as  [3] = '{16'hF0F0, 16'h1234, 16'h0001};
    logic [15:0] bs  [3] = '{16'h0FF0, 16'h00FF, 16'h0014};
    logic [18:0] exp;
    @(negedge clk);
    Ain = as[0]; Bin = bs[0]; ALUop = ops[0]; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = model(ops[i], as[i], bs[i]);
      @(posedge clk); #1;
      if (i < 2) begin
        Ain = as[i+1]; Bin = bs[i+1]; ALUop = ops[i+1];
      end else begin
        in_valid = 1'b0;
      end
      n_cmp++;
      if (out_valid !== 1'b1 || {Z, out} !== exp) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got valid=%b out=%h Z=%b, want 1 %h %b", i, out_valid,
                 out, Z, exp[15:0], exp[18:16]);
      end
    end
  endtask

  task automatic test_shifts();
    do_op(3'b110, 16'h8004, 16'h0002, "asr");
    do_op(3'b101, 16'h8004, 16'h0002, "shr");
    do_op(3'b100, 16'hABCD, 16'hFFF0, "shl_amt0");
  endtask

  task automatic test_mul();
    logic [15:0] held;
    do_op(3'b111, 16'h0003, 16'h0005, "mul_3x5");
    held = out;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out !== held) begin
      n_fail++;
      $display("FAIL mul_hold: got valid=%b out=%h, want 0 %h", out_valid, out, held);
    end
    do_op(3'b111, 16'h0100, 16'h0100, "mul_ovf_zero");
    do_op(3'b111, 16'hFFFF, 16'hFFFF, "mul_ffff");
  endtask

  task automatic test_mul_abort();
    int seen;
    do_op(3'b000, 16'h0003, 16'h0004, "pre_abort_add");
    @(negedge clk);
    Ain = 16'h0003; Bin = 16'h0005; ALUop = 3'b111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, in_ready, Z, out} !== {1'b0, 1'b1, 3'b000, 16'h0}) begin
      n_fail++;
      $display("FAIL abort_reset: got valid=%b ready=%b Z=%b out=%h, want 0 1 000 0000",
               out_valid, in_ready, Z, out);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (24) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_valid: got %0d out_valid pulses, want 0", seen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 120; i++) begin
      do_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_back_to_back();
    test_shifts();
    test_mul();
    test_mul_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
